i2c_master: RTL

- I2C controller (bus initiator) that issues single-byte register write and register read transactions to a 7-bit-addressed target.
- Its primary target is the board's I2C slave at address 0x55, which exposes the register file.
- Used on the FPGA side for loopback self-test, and as the stimulus engine in the slave's system bench.
- Drives open-drain SCL/SDA through output-enable signals: oe=1 pulls the line low, oe=0 releases it.

---
 rtl/i2c_master.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master.sv
// Single-byte I2C register write/read initiator with open-drain output enables.
// Every bus element is a phase of four quarters; SCL/SDA enables are registered.
module i2c_master #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam logic [15:0] CNT_MAX = 16'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP, DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [1:0]  qtr_reg, qtr_next;
  logic [2:0]  bit_reg, bit_next;
  logic [1:0]  sel_reg, sel_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  rx_reg, rx_next;
  logic        ack_bit_reg, ack_bit_next;
  logic        rw_reg, rw_next;
  logic [6:0]  addr_reg, addr_next;
  logic [7:0]  reg_addr_reg, reg_addr_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic [7:0]  rdata_reg, rdata_next;
  logic        ack_err_reg, ack_err_next;
  logic        done_reg, done_next;
  logic        scl_reg, scl_next;
  logic        sda_reg, sda_next;
  logic        quarter_end, phase_end;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    qtr_next      = qtr_reg;
    bit_next      = bit_reg;
    sel_next      = sel_reg;
    shift_next    = shift_reg;
    rx_next       = rx_reg;
    ack_bit_next  = ack_bit_reg;
    rw_next       = rw_reg;
    addr_next     = addr_reg;
    reg_addr_next = reg_addr_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    ack_err_next  = ack_err_reg;
    done_next     = (state_reg == DONE);
    scl_next      = 1'b0;
    sda_next      = 1'b0;

    quarter_end = (cnt_reg == CNT_MAX);
    phase_end   = quarter_end && (qtr_reg == 2'd3);

    if (state_reg != IDLE && state_reg != DONE) begin
      cnt_next = quarter_end ? 16'd0 : cnt_reg + 16'd1;
      if (quarter_end) qtr_next = qtr_reg + 2'd1;
    end

    // sda_i is sampled on the last cycle of q2, while SCL is high
    if (quarter_end && qtr_reg == 2'd2) begin
      if (state_reg == RX_ACK)  ack_bit_next = sda_i;
      if (state_reg == RX_BYTE) rx_next = {rx_reg[6:0], sda_i};
    end

    case (state_reg)
      IDLE: if (start) begin
        state_next    = START;
        rw_next       = rw;
        addr_next     = slave_addr;
        reg_addr_next = reg_addr;
        wdata_next    = wdata;
        ack_err_next  = 1'b0;
        cnt_next      = 16'd0;
        qtr_next      = 2'd0;
      end
      START: if (phase_end) begin
        state_next = TX_BYTE;
        shift_next = {addr_reg, 1'b0};
        bit_next   = 3'd0;
        sel_next   = 2'd0;
      end
      TX_BYTE: if (phase_end) begin
        if (bit_reg == 3'd7) begin
          state_next = RX_ACK;
        end else begin
          bit_next   = bit_reg + 3'd1;
          shift_next = {shift_reg[6:0], 1'b0};
        end
      end
      RX_ACK: if (phase_end) begin
        bit_next = 3'd0;
        if (ack_bit_reg) begin
          ack_err_next = 1'b1;
          state_next   = STOP;
        end else begin
          case (sel_reg)
            2'd0: begin
              state_next = TX_BYTE;
              shift_next = reg_addr_reg;
              sel_next   = 2'd1;
            end
            2'd1: begin
              if (rw_reg) begin
                state_next = RSTART;
              end else begin
                state_next = TX_BYTE;
                shift_next = wdata_reg;
                sel_next   = 2'd2;
              end
            end
            2'd2:    state_next = STOP;
            default: state_next = RX_BYTE;
          endcase
        end
      end
      RSTART: if (phase_end) begin
        state_next = TX_BYTE;
        shift_next = {addr_reg, 1'b1};
        sel_next   = 2'd3;
        bit_next   = 3'd0;
      end
      RX_BYTE: if (phase_end) begin
        if (bit_reg == 3'd7) state_next = TX_NACK;
        else bit_next = bit_reg + 3'd1;
      end
      TX_NACK: if (phase_end) begin
        state_next = STOP;
        rdata_next = rx_reg;
      end
      STOP:    if (phase_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Line levels for the quarter about to begin; q0 keeps SDA where it was
    case (state_next)
      START: sda_next = qtr_next[1];
      TX_BYTE: begin
        scl_next = !qtr_next[1];
        sda_next = (qtr_next == 2'd0) ? sda_reg : !shift_next[7];
      end
      RX_ACK, RX_BYTE, TX_NACK: begin
        scl_next = !qtr_next[1];
        sda_next = (qtr_next == 2'd0) ? sda_reg : 1'b0;
      end
      RSTART: begin
        scl_next = !qtr_next[1];
        sda_next = (qtr_next == 2'd0) ? sda_reg : (qtr_next == 2'd3);
      end
      STOP: begin
        scl_next = !qtr_next[1];
        sda_next = (qtr_next == 2'd0) ? sda_reg : (qtr_next != 2'd3);
      end
      default: begin
        scl_next = 1'b0;
        sda_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      qtr_reg      <= '0;
      bit_reg      <= '0;
      sel_reg      <= '0;
      shift_reg    <= '0;
      rx_reg       <= '0;
      ack_bit_reg  <= 1'b0;
      rw_reg       <= 1'b0;
      addr_reg     <= '0;
      reg_addr_reg <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      ack_err_reg  <= 1'b0;
      done_reg     <= 1'b0;
      scl_reg      <= 1'b0;
      sda_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      qtr_reg      <= qtr_next;
      bit_reg      <= bit_next;
      sel_reg      <= sel_next;
      shift_reg    <= shift_next;
      rx_reg       <= rx_next;
      ack_bit_reg  <= ack_bit_next;
      rw_reg       <= rw_next;
      addr_reg     <= addr_next;
      reg_addr_reg <= reg_addr_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      ack_err_reg  <= ack_err_next;
      done_reg     <= done_next;
      scl_reg      <= scl_next;
      sda_reg      <= sda_next;
    end
  end

  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign ack_err = ack_err_reg;
  assign rdata   = rdata_reg;
  assign scl_oe  = scl_reg;
  assign sda_oe  = sda_reg;

endmodule
